// File: rtl/prime_sieve.sv
// rtl/prime_sieve.sv - Sieve of Eratosthenes prime generator streaming primes up to MAX_N forever
module prime_sieve #(
  parameter int MAX_N = 511
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [8:0] primeNumber,
  output logic       loop
);

  localparam int IW = $clog2(MAX_N + 1);

  typedef enum logic [1:0] {SEL, MARK, EMIT} state_t;

  state_t       state, state_n;
  logic [MAX_N:0] flag;
  logic [9:0]   p, p_n;
  logic [9:0]   m, m_n;
  logic [8:0]   idx, idx_n;
  logic [8:0]   prime_n;
  logic         wrapped, wrapped_n;
  logic         loop_n;
  logic         mark_en;
  logic [19:0]  p_sq;
  logic [10:0]  m_next;
  logic         p_flag;
  logic         idx_flag;

  // Widened arithmetic so p*p and m+p can never wrap before the bound compare
  assign p_sq     = {10'd0, p} * {10'd0, p};
  assign m_next   = {1'b0, m} + {1'b0, p};
  assign p_flag   = flag[p[IW-1:0]];
  assign idx_flag = flag[idx[IW-1:0]];

  always_comb begin
    state_n   = state;
    p_n       = p;
    m_n       = m;
    idx_n     = idx;
    prime_n   = primeNumber;
    wrapped_n = wrapped;
    loop_n    = 1'b0;
    mark_en   = 1'b0;
    case (state)
      SEL: begin
        if (p_sq > 20'(MAX_N)) begin
          state_n = EMIT;
          idx_n   = 9'd2;
        end else if (p_flag) begin
          p_n = p + 10'd1;
        end else begin
          m_n     = p_sq[9:0];
          state_n = MARK;
        end
      end
      MARK: begin
        mark_en = 1'b1;
        if (m_next > 11'(MAX_N)) begin
          p_n     = p + 10'd1;
          state_n = SEL;
        end else begin
          m_n = m_next[9:0];
        end
      end
      EMIT: begin
        if (!idx_flag) prime_n = idx;
        // The first emission of 2 is not a wrap; only later passes pulse loop
        if (idx == 9'd2 && wrapped) loop_n = 1'b1;
        if (idx == 9'(MAX_N)) begin
          idx_n     = 9'd2;
          wrapped_n = 1'b1;
        end else begin
          idx_n = idx + 9'd1;
        end
      end
      default: state_n = SEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEL;
      p           <= 10'd2;
      m           <= 10'd0;
      idx         <= 9'd2;
      primeNumber <= 9'd0;
      loop        <= 1'b0;
      wrapped     <= 1'b0;
    end else begin
      state       <= state_n;
      p           <= p_n;
      m           <= m_n;
      idx         <= idx_n;
      primeNumber <= prime_n;
      loop        <= loop_n;
      wrapped     <= wrapped_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= '0;
    end else if (mark_en) begin
      flag[m[IW-1:0]] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prime_sieve.sv
// tb/tb_prime_sieve.sv - directed self-checking bench for prime_sieve (MAX_N=511 and MAX_N=30)
module tb_prime_sieve;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] prime_big, prime_small;
  logic       loop_big, loop_small;

  int total = 0;
  int bad = 0;
  int exp_big[$];
  int small_exp[10] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
  int lat_clean, lat_rerun;

  always #5 clk = ~clk;

  prime_sieve #(.MAX_N(511)) dut_big (
    .clk(clk), .rst_n(rst_n), .primeNumber(prime_big), .loop(loop_big)
  );

  prime_sieve #(.MAX_N(30)) dut_small (
    .clk(clk), .rst_n(rst_n), .primeNumber(prime_small), .loop(loop_small)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic first_pass(input string tag, output int lat);
    int cyc, n, t509, lastp, sawloop;
    logic [8:0] prev;
    cyc = 0;
    sawloop = 0;
    while (prime_big == 9'd0 && cyc < 800) begin
      @(negedge clk);
      cyc++;
      if (loop_big) sawloop++;
    end
    lat = cyc;
    check({tag, "_emit_lt700"}, int'(cyc < 700), 1);
    check({tag, "_sieve_loop_quiet"}, sawloop, 0);
    check({tag, "_first"}, prime_big, 2);
    check({tag, "_loop_first2"}, loop_big, 0);
    n = 1;
    prev = prime_big;
    lastp = prime_big;
    t509 = -1;
    cyc = 0;
    while (cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (prime_big != prev) begin
        prev = prime_big;
        if (prime_big == 9'd2) break;
        check($sformatf("%s_seq%0d", tag, n), prime_big,
              (n < exp_big.size()) ? exp_big[n] : 0);
        check($sformatf("%s_loop_mid%0d", tag, n), loop_big, 0);
        lastp = prime_big;
        n++;
        if (prime_big == 9'd509) t509 = cyc;
      end
    end
    check({tag, "_count"}, n, 97);
    check({tag, "_last"}, lastp, 509);
    check({tag, "_hold509"}, cyc - t509, 3);
    check({tag, "_period"}, cyc, 510);
    check({tag, "_wrap_val"}, prime_big, 2);
    check({tag, "_wrap_loop"}, loop_big, 1);
  endtask

  task automatic more_passes();
    int cyc, pulses, last;
    pulses = 1;
    last = 0;
    cyc = 0;
    repeat (4 * 510 + 20) begin
      @(negedge clk);
      cyc++;
      if (loop_big) begin
        check("big_loop_at_2", prime_big, 2);
        check("big_loop_gap", cyc - last, 510);
        last = cyc;
        pulses++;
      end
    end
    check("big_loop_count_5pass", pulses, 5);
  endtask

  initial begin
    for (int i = 2; i <= 511; i++)
      if (is_prime(i)) exp_big.push_back(i);

    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_prime_big", prime_big, 0);
    check("rst_loop_big", loop_big, 0);
    check("rst_prime_small", prime_small, 0);
    check("rst_loop_small", loop_small, 0);
    rst_n = 1'b1;

    fork
      begin : big_run
        first_pass("clean", lat_clean);
        more_passes();
      end
      begin : small_run
        int cyc, n;
        logic [8:0] prev;
        cyc = 0;
        while (prime_small == 9'd0 && cyc < 200) begin
          @(negedge clk);
          cyc++;
        end
        check("small_first", prime_small, 2);
        check("small_loop_first2", loop_small, 0);
        n = 1;
        prev = prime_small;
        cyc = 0;
        while (cyc < 100) begin
          @(negedge clk);
          cyc++;
          if (prime_small != prev) begin
            prev = prime_small;
            if (prime_small == 9'd2) break;
            if (n < 10) check($sformatf("small_seq%0d", n), prime_small, small_exp[n]);
            else check("small_extra", prime_small, 0);
            n++;
          end
        end
        check("small_count", n, 10);
        check("small_period", cyc, 29);
        check("small_wrap_loop", loop_small, 1);
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!loop_small && cyc < 100);
        check("small_loop_gap", cyc, 29);
        check("small_loop_val", prime_small, 2);
      end
    join

    // Asynchronous reset between edges while streaming
    #2 rst_n = 1'b0;
    #1;
    check("emit_rst_prime", prime_big, 0);
    check("emit_rst_loop", loop_big, 0);
    check("emit_rst_small", prime_small, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset again while the multiples of 2 are being marked
    repeat (100) @(negedge clk);
    check("mark_prime_quiet", prime_big, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mark_rst_prime", prime_big, 0);
    check("mark_rst_loop", loop_big, 0);
    @(negedge clk);
    rst_n = 1'b1;

    first_pass("rerun", lat_rerun);
    check("rerun_latency", lat_rerun, lat_clean);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
